// File: rtl/store_rmw_if.sv
// Store request / data-memory bundle between the datapath, the RMW sequencer and memory.
// slave = sequencer side, master = datapath/memory side.
interface store_rmw_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  store_size;
    logic [31:0] addr;
    logic [31:0] b_data;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        done;
    logic        busy;
    logic        addr_err;

    modport slave (
        input  req_valid, store_size, addr, b_data, mem_rdata,
        output req_ready, mem_addr, mem_wr, mem_wdata, done, busy, addr_err
    );

    modport master (
        output req_valid, store_size, addr, b_data, mem_rdata,
        input  req_ready, mem_addr, mem_wr, mem_wdata, done, busy, addr_err
    );
endinterface

// File: rtl/store_rmw_sequencer.sv
// Read-modify-write sequencer for sw/sh/sb stores; word stores write directly.
// Optional macro STORE_ALIGN_CHECK_EN: misaligned half/word requests finish at once with addr_err.
module store_rmw_sequencer #(
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    store_rmw_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_size;
    logic [31:0] r_b;
    logic [2:0]  r_cnt;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_wr;
    logic        r_done;
    logic        r_busy;
    logic        r_ready;
    logic        r_addr_err;

    logic        w_accept;
    logic        w_misaligned;

    function automatic logic [31:0] f_merge(input logic [1:0] size,
                                            input logic [31:0] old_word,
                                            input logic [31:0] b_val);
        logic [31:0] res;
        case (size)
            2'b10:   res = {old_word[31:16], b_val[15:0]};
            2'b11:   res = {old_word[31:8],  b_val[7:0]};
            default: res = b_val;
        endcase
        return res;
    endfunction

`ifdef STORE_ALIGN_CHECK_EN
    function automatic logic f_misaligned(input logic [1:0] size, input logic [31:0] a);
        logic res;
        case (size)
            2'b01:   res = (a[1:0] != 2'b00);
            2'b10:   res = a[0];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign w_misaligned = f_misaligned(bus.store_size, bus.addr);
`else
    assign w_misaligned = 1'b0;
`endif

    // r_ready mirrors IDLE but is held low through reset, so it gates acceptance.
    assign w_accept = bus.req_valid & r_ready;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_size      <= 2'b00;
            r_b         <= 32'd0;
            r_cnt       <= 3'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wr    <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_size  <= bus.store_size;
                        r_b     <= bus.b_data;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_misaligned) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_addr_err <= 1'b1;
                        end else begin
                            case (bus.store_size)
                                2'b01: begin
                                    r_state     <= ST_WRITE;
                                    r_mem_addr  <= bus.addr;
                                    r_mem_wdata <= bus.b_data;
                                    r_mem_wr    <= 1'b1;
                                end
                                2'b10, 2'b11: begin
                                    r_state    <= ST_READ;
                                    r_mem_addr <= bus.addr;
                                    r_cnt      <= 3'(MEM_RD_LAT);
                                end
                                default: begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_READ: begin
                    // Old word is merged straight into the write-data register.
                    if (r_cnt == 3'd0) begin
                        r_mem_wdata <= f_merge(r_size, bus.mem_rdata, r_b);
                        r_mem_wr    <= 1'b1;
                        r_state     <= ST_WRITE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_WRITE: begin
                    r_mem_wr <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_done     <= 1'b0;
                    r_addr_err <= 1'b0;
                    r_busy     <= 1'b0;
                    r_ready    <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_mem_wr   <= 1'b0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_ready    <= 1'b1;
                    r_addr_err <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.done      = r_done;
    assign bus.busy      = r_busy;
    assign bus.addr_err  = r_addr_err;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Directed bench for store_rmw_sequencer: one instance at read latency 1, one at latency 3.
// Memory returns a poison pattern until the configured latency has elapsed in READ.
module tb_store_rmw_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    store_rmw_if bus1();
    store_rmw_if bus3();

    store_rmw_sequencer #(.MEM_RD_LAT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    store_rmw_sequencer #(.MEM_RD_LAT(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

    logic [31:0] mem_word;
    logic [2:0]  rd_cnt1;
    logic [2:0]  rd_cnt3;
    int          wr1   = 0;
    int          done1 = 0;
    int          wr3   = 0;

    // Count cycles spent reading so data only appears once the latency has elapsed.
    always @(posedge clk) begin
        rd_cnt1 <= (!bus1.busy || bus1.mem_wr || bus1.done) ? 3'd0 : rd_cnt1 + 3'd1;
        rd_cnt3 <= (!bus3.busy || bus3.mem_wr || bus3.done) ? 3'd0 : rd_cnt3 + 3'd1;
        if (bus1.mem_wr === 1'b1) wr1 <= wr1 + 1;
        if (bus1.done === 1'b1) done1 <= done1 + 1;
        if (bus3.mem_wr === 1'b1) wr3 <= wr3 + 1;
    end

    assign bus1.mem_rdata = (rd_cnt1 == 3'd1) ? mem_word : 32'h5A5A_5A5A;
    assign bus3.mem_rdata = (rd_cnt3 == 3'd3) ? mem_word : 32'h5A5A_5A5A;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req1(input logic [1:0] size, input logic [31:0] a, input logic [31:0] b);
        bus1.req_valid  = 1'b1;
        bus1.store_size = size;
        bus1.addr       = a;
        bus1.b_data     = b;
    endtask

    int w0;
    int d0;

    initial begin
        reset_n         = 1'b0;
        mem_word        = 32'h1122_3344;
        bus1.req_valid  = 1'b0;
        bus1.store_size = 2'b00;
        bus1.addr       = 32'd0;
        bus1.b_data     = 32'd0;
        bus3.req_valid  = 1'b0;
        bus3.store_size = 2'b00;
        bus3.addr       = 32'd0;
        bus3.b_data     = 32'd0;

        // Reset state
        step();
        step();
        check_val("rst_mem_addr", bus1.mem_addr, 32'd0);
        check_val("rst_mem_wdata", bus1.mem_wdata, 32'd0);
        check_val("rst_mem_wr", 32'(bus1.mem_wr), 32'd0);
        check_val("rst_done", 32'(bus1.done), 32'd0);
        check_val("rst_busy", 32'(bus1.busy), 32'd0);
        check_val("rst_addr_err", 32'(bus1.addr_err), 32'd0);
        check_val("rst_ready", 32'(bus1.req_ready), 32'd0);
        reset_n = 1'b1;
        step();
        check_val("rel_ready", 32'(bus1.req_ready), 32'd1);

        // Word store
        w0 = wr1;
        req1(2'b01, 32'h40, 32'hDEAD_BEEF);
        step();
        bus1.req_valid = 1'b0;
        bus1.addr      = 32'hFFFF_FFFC;
        bus1.b_data    = 32'd0;
        check_val("w_wr", 32'(bus1.mem_wr), 32'd1);
        check_val("w_addr", bus1.mem_addr, 32'h40);
        check_val("w_wdata", bus1.mem_wdata, 32'hDEAD_BEEF);
        check_val("w_ready", 32'(bus1.req_ready), 32'd0);
        check_val("w_busy", 32'(bus1.busy), 32'd1);
        step();
        check_val("w_done", 32'(bus1.done), 32'd1);
        check_val("w_wr_off", 32'(bus1.mem_wr), 32'd0);
        step();
        check_val("w_done_off", 32'(bus1.done), 32'd0);
        check_val("w_idle_busy", 32'(bus1.busy), 32'd0);
        check_val("w_idle_ready", 32'(bus1.req_ready), 32'd1);
        check_val("w_nwrites", 32'(wr1 - w0), 32'd1);

        // Halfword RMW, latency 1
        w0 = wr1;
        req1(2'b10, 32'h80, 32'hAAAA_BBBB);
        step();
        bus1.req_valid = 1'b0;
        bus1.b_data    = 32'd0;
        check_val("h_rd_wr", 32'(bus1.mem_wr), 32'd0);
        check_val("h_rd_addr", bus1.mem_addr, 32'h80);
        step();
        check_val("h_rd2_wr", 32'(bus1.mem_wr), 32'd0);
        step();
        check_val("h_wr", 32'(bus1.mem_wr), 32'd1);
        check_val("h_wdata", bus1.mem_wdata, 32'h1122_BBBB);
        check_val("h_addr", bus1.mem_addr, 32'h80);
        step();
        check_val("h_done", 32'(bus1.done), 32'd1);
        check_val("h_wr_off", 32'(bus1.mem_wr), 32'd0);
        step();
        check_val("h_idle_ready", 32'(bus1.req_ready), 32'd1);
        check_val("h_wdata_hold", bus1.mem_wdata, 32'h1122_BBBB);
        check_val("h_nwrites", 32'(wr1 - w0), 32'd1);

        // Back-to-back with req_valid held high
        w0 = wr1;
        req1(2'b01, 32'h44, 32'h0BAD_F00D);
        step();
        bus1.addr   = 32'h48;
        bus1.b_data = 32'h1234_5678;
        check_val("bb_wdata1", bus1.mem_wdata, 32'h0BAD_F00D);
        check_val("bb_ready1", 32'(bus1.req_ready), 32'd0);
        step();
        check_val("bb_ready_done", 32'(bus1.req_ready), 32'd0);
        check_val("bb_done1", 32'(bus1.done), 32'd1);
        step();
        check_val("bb_idle_ready", 32'(bus1.req_ready), 32'd1);
        check_val("bb_idle_wr", 32'(bus1.mem_wr), 32'd0);
        step();
        bus1.req_valid = 1'b0;
        check_val("bb_wr2", 32'(bus1.mem_wr), 32'd1);
        check_val("bb_wdata2", bus1.mem_wdata, 32'h1234_5678);
        check_val("bb_addr2", bus1.mem_addr, 32'h48);
        step();
        step();
        check_val("bb_nwrites", 32'(wr1 - w0), 32'd2);

        // No-op store
        w0 = wr1;
        req1(2'b00, 32'h50, 32'h0);
        step();
        bus1.req_valid = 1'b0;
        check_val("nop_done", 32'(bus1.done), 32'd1);
        check_val("nop_wr", 32'(bus1.mem_wr), 32'd0);
        step();
        check_val("nop_ready", 32'(bus1.req_ready), 32'd1);
        check_val("nop_nwrites", 32'(wr1 - w0), 32'd0);

        // Reset during the READ of a byte store
        w0 = wr1;
        d0 = done1;
        req1(2'b11, 32'h60, 32'h0000_00CC);
        step();
        bus1.req_valid = 1'b0;
        check_val("rm_busy", 32'(bus1.busy), 32'd1);
        reset_n = 1'b0;
        step();
        check_val("rm_addr", bus1.mem_addr, 32'd0);
        check_val("rm_wr", 32'(bus1.mem_wr), 32'd0);
        check_val("rm_busy0", 32'(bus1.busy), 32'd0);
        check_val("rm_ready0", 32'(bus1.req_ready), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check_val("rm_ready1", 32'(bus1.req_ready), 32'd1);
        step();
        step();
        check_val("rm_nwrites", 32'(wr1 - w0), 32'd0);
        check_val("rm_ndone", 32'(done1 - d0), 32'd0);

        // Misaligned halfword
        w0 = wr1;
        req1(2'b10, 32'h41, 32'h0000_BEEF);
        step();
        bus1.req_valid = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
        check_val("ma_done", 32'(bus1.done), 32'd1);
        check_val("ma_err", 32'(bus1.addr_err), 32'd1);
        check_val("ma_wr", 32'(bus1.mem_wr), 32'd0);
        step();
        check_val("ma_err_off", 32'(bus1.addr_err), 32'd0);
        check_val("ma_ready", 32'(bus1.req_ready), 32'd1);
        check_val("ma_nwrites", 32'(wr1 - w0), 32'd0);
`else
        check_val("ma_err", 32'(bus1.addr_err), 32'd0);
        check_val("ma_done", 32'(bus1.done), 32'd0);
        step();
        step();
        check_val("ma_wr", 32'(bus1.mem_wr), 32'd1);
        check_val("ma_wdata", bus1.mem_wdata, 32'h1122_BEEF);
        check_val("ma_addr", bus1.mem_addr, 32'h41);
        step();
        check_val("ma_rmw_done", 32'(bus1.done), 32'd1);
        check_val("ma_err_done", 32'(bus1.addr_err), 32'd0);
        step();
        check_val("ma_nwrites", 32'(wr1 - w0), 32'd1);
`endif

        // Byte RMW on the latency-3 instance
        bus3.req_valid  = 1'b1;
        bus3.store_size = 2'b11;
        bus3.addr       = 32'h90;
        bus3.b_data     = 32'h0000_00CC;
        for (int c = 1; c <= 6; c++) begin
            step();
            bus3.req_valid = 1'b0;
            bus3.b_data    = 32'hFFFF_FFFF;
            check_val("l3_busy", 32'(bus3.busy), 32'd1);
            check_val("l3_wr", 32'(bus3.mem_wr), (c == 5) ? 32'd1 : 32'd0);
            check_val("l3_done", 32'(bus3.done), (c == 6) ? 32'd1 : 32'd0);
            if (c == 5) check_val("l3_wdata", bus3.mem_wdata, 32'h1122_33CC);
        end
        step();
        check_val("l3_idle_busy", 32'(bus3.busy), 32'd0);
        check_val("l3_nwrites", 32'(wr3), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
